// File: rtl/rapids_mem.sv
// rapids_mem: dual-port (fetch / load-store) memory unit with registered, handshaked responses.
// Define RAPIDS_MEM_CLEAR_EN to zero the RAM word-by-word after every reset.

module rapids_mem #(
    parameter int unsigned MEM_WORDS     = 128,
    parameter int unsigned SPECIAL_WORDS = 15,
    parameter int unsigned RD_LATENCY    = 1,
    parameter logic [14:0] VGA_BASE      = 15'h1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        instr_segv,
    output logic        wait_instr,
    input  logic        data_rd,
    input  logic        data_wr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic        data_valid,
    output logic [31:0] data,
    output logic        data_segv,
    output logic        wait_data,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [23:0] vga_color,
    output logic        vga_plot
);

    localparam int unsigned AW      = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_LO  = 32'd16;
    localparam logic [31:0] RAM_HI  = 32'd16 + 32'(MEM_WORDS);
    localparam logic [31:0] SPEC_HI = 32'(SPECIAL_WORDS);
    localparam logic [1:0]  LAT_M1  = 2'(RD_LATENCY - 1);
    localparam logic        ST_IDLE = 1'b0;
    localparam logic        ST_BUSY = 1'b1;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wdat,
                                          input logic [3:0] be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdat[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0] ram [MEM_WORDS] = '{default: 32'h0};
    logic [31:0] spec_q [SPECIAL_WORDS];

    logic clearing;
`ifdef RAPIDS_MEM_CLEAR_EN
    logic [AW-1:0] clr_cnt_q;
    logic          clr_done_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
        end else if (!clr_done_q) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(MEM_WORDS - 1)) clr_done_q <= 1'b1;
        end
    end

    // Gated by reset_n so every output reads 0 while reset is held.
    assign clearing = reset_n & ~clr_done_q;
`else
    assign clearing = 1'b0;
`endif

    // Fetch port
    logic          i_state_q, i_pend_segv_q;
    logic [1:0]    i_cnt_q;
    logic [31:0]   i_pend_q, i_word, i_fire_word;
    logic          i_in_ram, i_ok, i_acc, i_fire, i_fire_segv;
    logic [AW-1:0] i_idx;

    always_comb begin
        i_in_ram = (instr_addr >= RAM_LO) && (instr_addr < RAM_HI);
        i_ok     = (instr_addr == 32'd0) || i_in_ram;
        i_idx    = i_in_ram ? AW'(instr_addr - RAM_LO) : '0;
        i_word   = i_ok ? ram[i_idx] : 32'd0;
    end

    assign wait_instr  = (i_state_q == ST_BUSY) | clearing;
    assign i_acc       = reset_n & instr_req & ~wait_instr;
    // Response registers load one cycle before the valid cycle.
    assign i_fire      = (i_acc && (LAT_M1 == 2'd0)) || ((i_state_q == ST_BUSY) && (i_cnt_q == 2'd1));
    assign i_fire_word = i_acc ? i_word : i_pend_q;
    assign i_fire_segv = i_acc ? ~i_ok : i_pend_segv_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i_state_q     <= ST_IDLE;
            i_cnt_q       <= 2'd0;
            i_pend_q      <= 32'd0;
            i_pend_segv_q <= 1'b0;
            instr         <= 32'd0;
            instr_valid   <= 1'b0;
            instr_segv    <= 1'b0;
        end else begin
            instr_valid <= i_fire;
            instr_segv  <= i_fire & i_fire_segv;
            if (i_fire) instr <= i_fire_word;
            if (i_acc) begin
                i_state_q     <= ST_BUSY;
                i_cnt_q       <= LAT_M1;
                i_pend_q      <= i_word;
                i_pend_segv_q <= ~i_ok;
            end else if (i_state_q == ST_BUSY) begin
                if (i_cnt_q == 2'd0) i_state_q <= ST_IDLE;
                else                 i_cnt_q   <= i_cnt_q - 2'd1;
            end
        end
    end

    // Data port
    logic          d_state_q, d_pend_segv_q, d_pend_upd_q;
    logic [1:0]    d_cnt_q, d_lat_m1;
    logic [31:0]   d_pend_q, d_word, d_fire_word;
    logic          d_in_ram, d_in_spec, d_in_vga, d_load, d_store, d_fault, d_upd;
    logic          d_acc, d_we, d_fire, d_fire_segv, d_fire_upd;
    logic [AW-1:0] d_idx;
    logic [3:0]    d_sidx;

    always_comb begin
        d_in_ram  = (data_addr >= RAM_LO) && (data_addr < RAM_HI);
        d_in_spec = (data_addr != 32'd0) && (data_addr <= SPEC_HI);
        d_in_vga  = (data_addr[31:17] == VGA_BASE);
        d_idx     = d_in_ram ? AW'(data_addr - RAM_LO) : '0;
        d_sidx    = d_in_spec ? 4'(data_addr - 32'd1) : 4'd0;
        d_load    = data_rd & ~data_wr;
        d_store   = data_wr & ~data_rd;
        d_fault   = (data_rd & data_wr) | (d_load & ~(d_in_ram | d_in_spec))
                  | (d_store & ~(d_in_ram | d_in_spec | d_in_vga));
        // Loads and faults update the held data word; clean stores leave it alone.
        d_upd     = d_load | d_fault;
        d_lat_m1  = d_load ? LAT_M1 : 2'd0;
        d_word    = 32'd0;
        if (d_load && d_in_ram)       d_word = ram[d_idx];
        else if (d_load && d_in_spec) d_word = spec_q[d_sidx];
    end

    assign wait_data   = (d_state_q == ST_BUSY) | clearing;
    assign d_acc       = reset_n & (data_rd | data_wr) & ~wait_data;
    assign d_we        = d_acc & d_store;
    assign d_fire      = (d_acc && (d_lat_m1 == 2'd0)) || ((d_state_q == ST_BUSY) && (d_cnt_q == 2'd1));
    assign d_fire_word = d_acc ? d_word : d_pend_q;
    assign d_fire_segv = d_acc ? d_fault : d_pend_segv_q;
    assign d_fire_upd  = d_acc ? d_upd : d_pend_upd_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d_state_q     <= ST_IDLE;
            d_cnt_q       <= 2'd0;
            d_pend_q      <= 32'd0;
            d_pend_segv_q <= 1'b0;
            d_pend_upd_q  <= 1'b0;
            data          <= 32'd0;
            data_valid    <= 1'b0;
            data_segv     <= 1'b0;
        end else begin
            data_valid <= d_fire;
            data_segv  <= d_fire & d_fire_segv;
            if (d_fire && d_fire_upd) data <= d_fire_word;
            if (d_acc) begin
                d_state_q     <= ST_BUSY;
                d_cnt_q       <= d_lat_m1;
                d_pend_q      <= d_word;
                d_pend_segv_q <= d_fault;
                d_pend_upd_q  <= d_upd;
            end else if (d_state_q == ST_BUSY) begin
                if (d_cnt_q == 2'd0) d_state_q <= ST_IDLE;
                else                 d_cnt_q   <= d_cnt_q - 2'd1;
            end
        end
    end

    // RAM is never reset; fetch reads above see the pre-store value in the same cycle.
    always_ff @(posedge clk) begin
`ifdef RAPIDS_MEM_CLEAR_EN
        if (clearing) ram[clr_cnt_q] <= 32'd0;
        else
`endif
        if (d_we && d_in_ram) ram[d_idx] <= merge(ram[d_idx], data_in, data_be);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SPECIAL_WORDS); i++) spec_q[i] <= 32'd0;
        end else if (d_we && d_in_spec) begin
            spec_q[d_sidx] <= merge(spec_q[d_sidx], data_in, data_be);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vga_plot  <= 1'b0;
            vga_x     <= 9'd0;
            vga_y     <= 8'd0;
            vga_color <= 24'd0;
        end else begin
            vga_plot <= d_we & d_in_vga;
            if (d_we && d_in_vga) begin
                vga_x     <= data_addr[8:0];
                vga_y     <= data_addr[16:9];
                vga_color <= data_in[23:0];
            end
        end
    end

endmodule

// File: tb/tb_rapids_mem.sv
// Scoreboard bench for rapids_mem: stimulus pushes expectations computed from an address-map
// model, a negedge monitor pops and compares whenever a response strobe appears.

module tb_rapids_mem;

    localparam int unsigned MW     = 128;
    localparam int unsigned SW     = 15;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned AWT    = $clog2(MW);
    localparam logic [14:0] VB     = 15'h1;

    logic        clk, reset_n;
    logic        instr_req, instr_valid, instr_segv, wait_instr;
    logic [31:0] instr_addr, instr;
    logic        data_rd, data_wr, data_valid, data_segv, wait_data;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_in, data;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [23:0] vga_color;
    logic        vga_plot;

    rapids_mem #(
        .MEM_WORDS(MW), .SPECIAL_WORDS(SW), .RD_LATENCY(RD_LAT), .VGA_BASE(VB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid),
        .instr(instr), .instr_segv(instr_segv), .wait_instr(wait_instr),
        .data_rd(data_rd), .data_wr(data_wr), .data_be(data_be), .data_addr(data_addr),
        .data_in(data_in), .data_valid(data_valid), .data(data), .data_segv(data_segv),
        .wait_data(wait_data), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
        .vga_plot(vga_plot)
    );

    typedef struct {
        logic [31:0] word;
        logic        segv;
        int          due;
    } iexp_t;

    typedef struct {
        logic [31:0] word;
        logic        segv;
        logic        upd;
        logic        plot;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [23:0] color;
        int          due;
    } dexp_t;

    iexp_t       iq[$];
    dexp_t       dq[$];
    logic [31:0] mem [MW];
    logic [31:0] spr [16];
    logic [31:0] held_i = 32'd0;
    logic [31:0] held_d = 32'd0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wdat,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wdat[8*b +: 8];
        return r;
    endfunction

    function automatic bit in_ram(input logic [31:0] a);
        return (a >= 32'd16) && (a < 32'(16 + MW));
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 32'($urandom_range(0, 20));
            1, 2:    return 32'(16 + $urandom_range(0, MW - 1));
            3:       return 32'(16 + MW + $urandom_range(0, 8));
            4:       return {VB, 17'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares every response strobe against the head of its queue.
    always @(negedge clk) begin
        iexp_t ie;
        dexp_t de;
        if (instr_valid) begin
            if (iq.size() == 0) chk("instr_unexpected_valid", 32'(instr_valid), 32'd0);
            else begin
                ie = iq.pop_front();
                chk("instr_word", instr, ie.word);
                chk("instr_segv", 32'(instr_segv), 32'(ie.segv));
                chk("instr_latency", cyc, ie.due);
                held_i = ie.word;
            end
        end else begin
            chk("instr_held", instr, held_i);
            if (iq.size() > 0 && iq[0].due < cyc) begin
                chk("instr_missing_valid", 32'(instr_valid), 32'd1);
                void'(iq.pop_front());
            end
        end
        if (data_valid) begin
            if (dq.size() == 0) chk("data_unexpected_valid", 32'(data_valid), 32'd0);
            else begin
                de = dq.pop_front();
                chk("data_segv", 32'(data_segv), 32'(de.segv));
                chk("data_latency", cyc, de.due);
                if (de.upd) held_d = de.word;
                chk("data_word", data, held_d);
                chk("vga_plot", 32'(vga_plot), 32'(de.plot));
                if (de.plot) begin
                    chk("vga_xy", 32'({vga_x, vga_y}), 32'({de.x, de.y}));
                    chk("vga_color", 32'(vga_color), 32'(de.color));
                end
            end
        end else begin
            chk("data_held", data, held_d);
            if (vga_plot) chk("vga_plot_stray", 32'(vga_plot), 32'd0);
            if (dq.size() > 0 && dq[0].due < cyc) begin
                chk("data_missing_valid", 32'(data_valid), 32'd1);
                void'(dq.pop_front());
            end
        end
        if (!reset_n) begin
            iq.delete();
            dq.delete();
            held_i = 32'd0;
            held_d = 32'd0;
        end
    end

    // Issue a fetch and/or data request in one cycle; called at posedge+1.
    task automatic op(input bit do_i, input logic [31:0] ia, input bit do_d, input bit rd,
                      input bit wr, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] din);
        int guard = 0;
        while ((do_i && wait_instr) || (do_d && wait_data)) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                chk("port_wait_timeout", 32'({wait_instr, wait_data}), 32'd0);
                return;
            end
        end
        if (do_i) begin
            iexp_t e;
            logic [AWT-1:0] ri;
            ri     = AWT'(ia - 32'd16);
            e.word = 32'd0;
            e.segv = 1'b0;
            if (ia == 32'd0)    e.word = mem[0];
            else if (in_ram(ia)) e.word = mem[ri];
            else                e.segv = 1'b1;
            e.due = cyc + RD_LAT;
            iq.push_back(e);
            instr_req  = 1'b1;
            instr_addr = ia;
        end
        if (do_d) begin
            dexp_t e;
            logic [AWT-1:0] ri;
            bit r, s, v;
            ri = AWT'(a - 32'd16);
            r  = in_ram(a);
            s  = (a >= 32'd1) && (a <= 32'(SW));
            v  = (a[31:17] == VB);
            e.word = 32'd0; e.segv = 1'b0; e.upd = 1'b0; e.plot = 1'b0;
            e.x = 9'd0; e.y = 8'd0; e.color = 24'd0; e.due = cyc + 1;
            if (rd && wr) begin
                e.segv = 1'b1; e.upd = 1'b1;
            end else if (rd) begin
                e.upd = 1'b1;
                e.due = cyc + RD_LAT;
                if (r)      e.word = mem[ri];
                else if (s) e.word = spr[4'(a)];
                else        e.segv = 1'b1;
            end else begin
                if (r)      mem[ri] = merge(mem[ri], din, be);
                else if (s) spr[4'(a)] = merge(spr[4'(a)], din, be);
                else if (v) begin
                    e.plot = 1'b1; e.x = a[8:0]; e.y = a[16:9]; e.color = din[23:0];
                end else begin
                    e.segv = 1'b1; e.upd = 1'b1;
                end
            end
            dq.push_back(e);
            data_rd = rd; data_wr = wr; data_be = be; data_addr = a; data_in = din;
        end
        @(posedge clk); #1;
        instr_req = 1'b0; data_rd = 1'b0; data_wr = 1'b0;
        if (do_i) chk("wait_instr_busy", 32'(wait_instr), 32'd1);
        if (do_d) chk("wait_data_busy", 32'(wait_data), 32'd1);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        instr_req = 1'b0; data_rd = 1'b0; data_wr = 1'b0;
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
        chk("rst_instr", instr, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_flags", 32'({instr_valid, instr_segv, wait_instr, data_valid, data_segv,
                              wait_data, vga_plot}), 32'd0);
        chk("rst_vga_xy", 32'({vga_x, vga_y}), 32'd0);
        chk("rst_vga_color", 32'(vga_color), 32'd0);
        for (int i = 0; i < 16; i++) spr[i] = 32'd0;
        reset_n = 1'b1;
        #1;
`ifdef RAPIDS_MEM_CLEAR_EN
        begin
            int n_wait = 0;
            while (wait_data && n_wait < 4 * MW) begin
                n_wait++;
                @(posedge clk); #1;
            end
            chk("clear_wait_cycles", n_wait, MW);
            for (int i = 0; i < MW; i++) mem[i] = 32'd0;
        end
`else
        chk("wait_data_after_reset", 32'(wait_data), 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] va;
        reset_n = 1'b0;
        instr_req = 1'b0; instr_addr = 32'd0;
        data_rd = 1'b0; data_wr = 1'b0; data_be = 4'd0; data_addr = 32'd0; data_in = 32'd0;
        for (int i = 0; i < MW; i++) mem[i] = 32'd0;
        for (int i = 0; i < 16; i++) spr[i] = 32'd0;
        do_reset(3);

        // Byte-enabled store over zero, then load back.
        op(0, 0, 1, 0, 1, 4'b0101, 32'd20, 32'hDEADBEEF);
        op(0, 0, 1, 1, 0, 4'h0, 32'd20, 32'd0);

        // Fault map.
        op(0, 0, 1, 0, 1, 4'hF, 32'd16, 32'hA5A50001);
        op(1, 32'd0, 0, 0, 0, 4'h0, 32'd0, 32'd0);
        op(1, 32'd5, 0, 0, 0, 4'h0, 32'd0, 32'd0);
        op(0, 0, 1, 1, 0, 4'h0, 32'd0, 32'd0);
        op(0, 0, 1, 1, 0, 4'h0, 32'(16 + MW), 32'd0);
        op(0, 0, 1, 1, 0, 4'h0, 32'h00020000, 32'd0);
        op(0, 0, 1, 1, 1, 4'hF, 32'd20, 32'hFFFFFFFF);
        op(0, 0, 1, 1, 0, 4'h0, 32'd20, 32'd0);
        op(0, 0, 1, 0, 1, 4'h0, 32'd20, 32'h12345678);
        op(0, 0, 1, 1, 0, 4'h0, 32'd20, 32'd0);

        // VGA store then faulting load from the same address.
        va = {VB, 17'd0} | (32'd37 << 9) | 32'd200;
        op(0, 0, 1, 0, 1, 4'b0001, va, 32'h00FF8800);
        op(0, 0, 1, 1, 0, 4'h0, va, 32'd0);

        // Same-cycle fetch and store to one word.
        op(0, 0, 1, 0, 1, 4'hF, 32'd40, 32'd1);
        op(1, 32'd40, 1, 0, 1, 4'hF, 32'd40, 32'd2);
        op(1, 32'd40, 0, 0, 0, 4'h0, 32'd0, 32'd0);

        // Special registers clear on reset; RAM keeps its contents.
        op(0, 0, 1, 0, 1, 4'hF, 32'd3, 32'h00001234);
        op(0, 0, 1, 1, 0, 4'h0, 32'd3, 32'd0);
        op(1, 32'd3, 0, 0, 0, 4'h0, 32'd0, 32'd0);
        do_reset(1);
        op(0, 0, 1, 1, 0, 4'h0, 32'd3, 32'd0);
        op(0, 0, 1, 1, 0, 4'h0, 32'd40, 32'd0);

        // Reset while a load is in flight drops its response.
        op(0, 0, 1, 1, 0, 4'h0, 32'd40, 32'd0);
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            chk("no_resp_after_reset", 32'(data_valid), 32'd0);
            @(posedge clk); #1;
        end

        for (int n = 0; n < 300; n++) begin
            int  sel, kind;
            bit  rd, wr;
            sel  = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            rd   = (kind <= 3) || (kind == 9);
            wr   = (kind >= 4);
            op(sel != 1, rand_addr(), sel != 0, rd, wr, 4'($urandom), rand_addr(), $urandom);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        repeat (8) begin @(posedge clk); #1; end
        chk("instr_queue_drained", iq.size(), 32'd0);
        chk("data_queue_drained", dq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
